// File: rtl/muldiv_hilo_unit.sv
// Iterative unsigned multiply/divide unit owning the HI/LO pair.
// Shift-add MULTU and restoring DIVU, one bit per cycle, plus MTHI/MTLO/MFHI/MFLO access.
module muldiv_hilo_unit #(
    parameter int          WIDTH   = 32,
    parameter logic [5:0]  F_MFHI  = 6'd16,
    parameter logic [5:0]  F_MTHI  = 6'd17,
    parameter logic [5:0]  F_MFLO  = 6'd18,
    parameter logic [5:0]  F_MTLO  = 6'd19,
    parameter logic [5:0]  F_MULTU = 6'd25,
    parameter logic [5:0]  F_DIVU  = 6'd27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DZ} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // acc: upper product half / partial remainder; wq: multiplier / dividend-quotient; opb: multiplicand / divisor
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] wq;
    logic [WIDTH-1:0] opb;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic             hilo_op;

    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (wq[0] ? opb : {WIDTH{1'b0}})};
        div_shift = {acc, wq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        // No borrow out of the trial subtraction means the quotient bit is 1
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    end

    assign busy    = (state != IDLE);
    assign hilo_op = (funct == F_MFHI) || (funct == F_MFLO) || (funct == F_MTHI) ||
                     (funct == F_MTLO) || (funct == F_MULTU) || (funct == F_DIVU);
    assign stall   = busy & start & hilo_op;

    always_comb begin
        rd_data = '0;
        if (funct == F_MFHI)      rd_data = hi;
        else if (funct == F_MFLO) rd_data = lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            wq    <= '0;
            opb   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (funct == F_MULTU) begin
                            opb   <= src_a;
                            wq    <= src_b;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else if (funct == F_DIVU) begin
                            wq    <= src_a;
                            opb   <= src_b;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= (src_b == '0) ? DZ : DIV;
                        end else if (funct == F_MTHI) begin
                            hi <= src_a;
                        end else if (funct == F_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    wq  <= {mul_sum[0], wq[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        hi    <= mul_sum[WIDTH:1];
                        lo    <= {mul_sum[0], wq[WIDTH-1:1]};
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                DIV: begin
                    acc <= div_rem;
                    wq  <= {wq[WIDTH-2:0], div_ge};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        lo    <= {wq[WIDTH-2:0], div_ge};
                        hi    <= div_rem;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                DZ: begin
                    // Divide by zero: HI gets the dividend, LO saturates to all ones
                    hi    <= wq;
                    lo    <= '1;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: a 32-bit instance for the main sequence and an
// 8-bit instance for the narrow-width multiply and back-to-back divide.
module tb_muldiv_hilo_unit;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, stall;
    logic [31:0] rd_data, hi, lo;

    logic        start8 = 1'b0;
    logic [5:0]  funct8 = 6'd0;
    logic [7:0]  src_a8 = '0;
    logic [7:0]  src_b8 = '0;
    logic        busy8, done8, stall8;
    logic [7:0]  rd_data8, hi8, lo8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .stall(stall), .rd_data(rd_data), .hi(hi), .lo(lo)
    );

    muldiv_hilo_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .funct(funct8), .src_a(src_a8), .src_b(src_b8),
        .busy(busy8), .done(done8), .stall(stall8), .rd_data(rd_data8), .hi(hi8), .lo(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles after the accepting edge until done rises (sel=1 watches the 8-bit unit)
    task automatic wait_done(input bit sel, output int n);
        n = 0;
        while (!(sel ? done8 : done) && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int miss;
        int seen;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        // MULTU max * max
        start = 1; funct = F_MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        tick();
        start = 0;
        check("mul_busy", busy, 1);
        check("mul_hi_hold", hi, 0);
        wait_done(0, n);
        check("mul_lat", n, 32);
        check("mul_hi", hi, 32'hFFFF_FFFE);
        check("mul_lo", lo, 32'h0000_0001);
        check("mul_done_busy", busy, 0);
        tick();
        check("mul_done_pulse", done, 0);

        // DIVU 100 / 7
        start = 1; funct = F_DIVU; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 0;
        repeat (5) tick();
        check("div_hi_hold", hi, 32'hFFFF_FFFE);
        wait_done(0, n);
        check("div_lat", n, 27);
        check("div_lo", lo, 32'd14);
        check("div_hi", hi, 32'd2);

        // DIVU max / 10
        start = 1; funct = F_DIVU; src_a = 32'hFFFF_FFFF; src_b = 32'd10;
        tick();
        start = 0;
        wait_done(0, n);
        check("div2_lat", n, 32);
        check("div2_lo", lo, 32'h1999_9999);
        check("div2_hi", hi, 32'd5);

        // DIVU by zero
        start = 1; funct = F_DIVU; src_a = 32'h1234; src_b = 32'd0;
        tick();
        start = 0;
        check("dz_busy", busy, 1);
        check("dz_done_early", done, 0);
        wait_done(0, n);
        check("dz_lat", n, 1);
        check("dz_hi", hi, 32'h1234);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_busy_after", busy, 0);

        // MULTU 3*5 with MFHI and a second MULTU presented while busy
        start = 1; funct = F_MULTU; src_a = 32'd3; src_b = 32'd5;
        tick();
        src_a = 32'd100; src_b = 32'd100;
        n = 0; miss = 0;
        while (!done && n < 100) begin
            funct = n[0] ? F_MULTU : F_MFHI;
            #1;
            if (!stall) miss++;
            tick();
            n++;
        end
        start = 0;
        check("stall_lat", n, 32);
        check("stall_miss", miss, 0);
        funct = F_MFLO;
        #1;
        check("mflo_15", rd_data, 32'd15);
        funct = F_MFHI;
        #1;
        check("mfhi_0", rd_data, 32'd0);
        tick();
        check("second_ignored", busy, 0);

        // Non-hilo funct while busy does not stall; idle MFHI does not stall
        start = 1; funct = F_MFHI;
        #1;
        check("idle_nostall", stall, 0);
        funct = F_MULTU; src_a = 32'd7; src_b = 32'd9;
        tick();
        funct = 6'd32;
        #1;
        check("other_nostall", stall, 0);
        check("other_rd0", rd_data, 0);
        start = 0;

        // Reset at cycle 10 of MULTU 7*9
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0;
        check("mrst_busy", busy, 0);
        check("mrst_hi", hi, 0);
        check("mrst_lo", lo, 0);
        seen = 0;
        repeat (40) begin
            tick();
            if (done) seen++;
        end
        check("mrst_nodone", seen, 0);

        // MTLO / MTHI then reads
        start = 1; funct = F_MTLO; src_a = 32'hDEAD_BEEF;
        tick();
        check("mtlo_busy", busy, 0);
        funct = F_MTHI; src_a = 32'hCAFE_0001;
        tick();
        start = 0;
        check("mthi_done", done, 0);
        funct = F_MFLO;
        #1;
        check("mflo_deadbeef", rd_data, 32'hDEAD_BEEF);
        funct = F_MFHI;
        #1;
        check("mfhi_cafe", rd_data, 32'hCAFE_0001);

        // 8-bit build: MULTU 0xFF*0xFF, then DIVU 200/16 presented in the done cycle
        start8 = 1; funct8 = F_MULTU; src_a8 = 8'hFF; src_b8 = 8'hFF;
        tick();
        start8 = 0;
        wait_done(1, n);
        check("m8_lat", n, 8);
        check("m8_hi", hi8, 8'hFE);
        check("m8_lo", lo8, 8'h01);
        start8 = 1; funct8 = F_DIVU; src_a8 = 8'd200; src_b8 = 8'd16;
        tick();
        start8 = 0;
        check("d8_b2b_busy", busy8, 1);
        check("d8_hi_hold", hi8, 8'hFE);
        wait_done(1, n);
        check("d8_lat", n, 8);
        check("d8_lo", lo8, 8'd12);
        check("d8_hi", hi8, 8'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
